sram_mem_ctrl: RTL and testbench

Memory-stage SRAM controller that consumes the EXE/MEM pipeline register outputs: memory read/write enables, ALU result as address, and Val_Rm as store data. It performs each 32-bit load/store as two 16-bit transfers on an external asynchronous SRAM. It returns a `ready` flag that the pipeline inverts into `freeze` for all stage registers, stalling them until the access completes. Load data goes to the MEM/WB register.

---
 rtl/sram_mem_ctrl_if.sv | 26 ++
 rtl/sram_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: pipeline-side bundle between the EXE/MEM register and
// the SRAM controller.
//   rd_en, wr_en  : load / store request for the current memory instruction
//   address       : byte address (ALU result)
//   write_data    : store data (Val_Rm)
//   read_data     : registered load result, feeds the MEM/WB register
//   ready         : 0 stalls every pipeline stage (freeze = ~ready)
// master = pipeline side, slave = controller side.
interface sram_mem_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: memory-stage controller that turns each 32-bit load/store
// into two 16-bit transfers (low half, then high half) on an external
// asynchronous SRAM, holding the pipeline with ready=0 until done.
//   clk_i        : rising-edge clock
//   rst_ni       : asynchronous active-low reset
//   bus          : pipeline handshake (sram_mem_ctrl_if.slave)
//   sram_dq_io   : SRAM data bus, driven only during write phases
//   sram_addr_o  : SRAM half-word address, 0 when not transferring
//   sram_we_n_o  : SRAM write enable, active-low
// HALF_CYCLES sets the clocks per 16-bit transfer (1..15).
//
// state  | meaning
// S_IDLE | waiting for rd_en|wr_en; latches the request on that edge
// S_LOW  | transferring half-word {w,0} for HALF_CYCLES clocks
// S_HIGH | transferring half-word {w,1} for HALF_CYCLES clocks
// S_DONE | access finished, ready=1 for one clock, then back to IDLE
module sram_mem_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sram_mem_ctrl_if.slave bus,
  inout  wire  [15:0]    sram_dq_io,
  output logic [17:0]    sram_addr_o,
  output logic           sram_we_n_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;

  localparam logic [3:0] LAST_CNT = 4'(HALF_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        phase_last;
  logic [31:0] byte_off;
  logic        unused_bits;
  logic        ready;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req        = bus.rd_en | bus.wr_en;
  // Wrapping subtraction; only w[16:0] reaches the 18-bit half-word address.
  assign byte_off   = bus.address - 32'(BASE_ADDR);
  assign unused_bits = ^{byte_off[31:19], byte_off[1:0]};
  assign phase_last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_wr_q <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (state_q == S_IDLE && req) begin
        op_wr_q <= bus.wr_en;  // write wins when both are set
        word_q  <= byte_off[18:2];
        wdata_q <= bus.write_data;
      end
      // Sample the SRAM as late as possible in each read phase.
      if (!op_wr_q && phase_last) begin
        if (state_q == S_LOW)  rdata_q[15:0]  <= sram_dq_io;
        if (state_q == S_HIGH) rdata_q[31:16] <= sram_dq_io;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    sram_addr_o = 18'd0;
    sram_we_n_o = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = 16'd0;
    unique case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
        end
      end
      S_LOW: begin
        sram_addr_o = {word_q, 1'b0};
        if (op_wr_q) begin
          sram_we_n_o = 1'b0;
          dq_oe       = 1'b1;
          dq_out      = wdata_q[15:0];
        end
        if (phase_last) begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        sram_addr_o = {word_q, 1'b1};
        if (op_wr_q) begin
          sram_we_n_o = 1'b0;
          dq_oe       = 1'b1;
          dq_out      = wdata_q[31:16];
        end
        if (phase_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sram_dq_io    = dq_oe ? dq_out : 16'bz;
  assign bus.ready     = ready;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;
  localparam int H = 2;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_ha;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          stall;
  } sb_t;

  logic clk;
  logic rst_n;

  sram_mem_ctrl_if bus_m ();
  sram_mem_ctrl_if bus_1 ();
  sram_mem_ctrl_if bus_3 ();

  wire  [15:0] dq_m, dq_1, dq_3;
  logic [17:0] addr_m, addr_1, addr_3;
  logic        we_n_m, we_n_1, we_n_3;

  logic [15:0] mem [0:63];

  int   checks   = 0;
  int   failures = 0;
  sb_t  sb_q[$];
  int   zcnt;
  vec_t vecs[7];

  sram_mem_ctrl #(.BASE_ADDR(1024), .HALF_CYCLES(H)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_m),
    .sram_dq_io(dq_m), .sram_addr_o(addr_m), .sram_we_n_o(we_n_m)
  );

  sram_mem_ctrl #(.BASE_ADDR(1024), .HALF_CYCLES(1)) u_dut_h1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_1),
    .sram_dq_io(dq_1), .sram_addr_o(addr_1), .sram_we_n_o(we_n_1)
  );

  sram_mem_ctrl #(.BASE_ADDR(1024), .HALF_CYCLES(3)) u_dut_h3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_3),
    .sram_dq_io(dq_3), .sram_addr_o(addr_3), .sram_we_n_o(we_n_3)
  );

  // Asynchronous SRAM model with output enable tied active.
  assign dq_m = we_n_m ? mem[addr_m[5:0]] : 16'bz;
  always @(posedge clk) if (!we_n_m) mem[addr_m[5:0]] <= dq_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] sw_addr(input int h, input int k);
    if (k >= 1 && k <= h) return 18'h3FFFE;
    if (k > h && k <= 2*h) return 18'h3FFFF;
    return 18'h0;
  endfunction

  function automatic logic sw_ready(input int h, input int k);
    return (k > 2*h) ? 1'b1 : 1'b0;
  endfunction

  // Scoreboard consumer: a run of ready=0 ended by ready=1 is one access.
  initial begin
    sb_t e;
    zcnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) zcnt = 0;
      else if (!bus_m.ready) zcnt++;
      else if (zcnt > 0) begin
        if (sb_q.size() == 0) chk("sb_unexpected_access", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("sb_read_data", bus_m.read_data, e.rdata);
          chk("sb_stall_cycles", zcnt, e.stall);
        end
        zcnt = 0;
      end
    end
  end

  // Caller is at a negedge in IDLE; returns at the negedge of the DONE cycle.
  task automatic txn(input vec_t v);
    sb_t e;
    e.rdata = v.exp_rd;
    e.stall = 2*H + 1;
    sb_q.push_back(e);
    bus_m.rd_en      = v.rd;
    bus_m.wr_en      = v.wr;
    bus_m.address    = v.addr;
    bus_m.write_data = v.wdata;
    #1;
    chk("c0_ready", bus_m.ready, 0);
    chk("c0_addr", addr_m, 0);
    chk("c0_we_n", we_n_m, 1);
    for (int k = 1; k <= 2*H + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_m.rd_en      = 1'b0;
        bus_m.wr_en      = 1'b0;
        bus_m.address    = 32'hFFFF_FFF0;
        bus_m.write_data = 32'h5555_AAAA;
      end
      if (k <= 2*H) begin
        chk("busy_ready", bus_m.ready, 0);
        chk("phase_addr", addr_m, v.exp_ha | ((k > H) ? 18'd1 : 18'd0));
        chk("phase_we_n", we_n_m, v.wr ? 0 : 1);
        if (v.wr) chk("phase_dq", dq_m, (k > H) ? v.wdata[31:16] : v.wdata[15:0]);
      end else begin
        chk("done_ready", bus_m.ready, 1);
        chk("done_addr", addr_m, 0);
        chk("done_we_n", we_n_m, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   z1, z3;

    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0000_0000, 18'd4, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0000_0000, 18'd0, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 18'd2, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1029, 32'h0000_0000, 18'd2, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd1032, 32'h0000_0000, 18'd4, 32'hDEADBEEF};

    rst_n = 1'b0;
    bus_m.rd_en = 0; bus_m.wr_en = 0; bus_m.address = 0; bus_m.write_data = 0;
    bus_1.rd_en = 0; bus_1.wr_en = 0; bus_1.address = 0; bus_1.write_data = 0;
    bus_3.rd_en = 0; bus_3.wr_en = 0; bus_3.address = 0; bus_3.write_data = 0;
    #1;
    chk("rst_ready", bus_m.ready, 1);
    chk("rst_addr", addr_m, 0);
    chk("rst_we_n", we_n_m, 1);
    chk("rst_read_data", bus_m.read_data, 0);
    bus_m.rd_en = 1'b1;
    #1;
    chk("rst_ready_with_req", bus_m.ready, 0);
    bus_m.rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", bus_m.ready, 1);
      chk("idle_addr", addr_m, 0);
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      txn(vecs[i]);
      if (i == 2) begin
        chk("prio_mem_lo", mem[0], 16'h5678);
        chk("prio_mem_hi", mem[1], 16'h1234);
      end
      @(negedge clk);
      chk("gap_ready", bus_m.ready, 1);
    end

    // Store then load held across DONE -> IDLE.
    @(negedge clk);
    v = '{1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 18'd6, 32'hDEADBEEF};
    txn(v);
    bus_m.rd_en   = 1'b1;
    bus_m.address = 32'd1036;
    #1;
    chk("b2b_done_ready", bus_m.ready, 1);
    @(negedge clk);
    v = '{1'b1, 1'b0, 32'd1036, 32'h0000_0000, 18'd6, 32'h0BADC0DE};
    txn(v);
    @(negedge clk);
    chk("b2b_gap_ready", bus_m.ready, 1);

    // Reset in the middle of the HIGH phase of a write.
    @(negedge clk);
    bus_m.wr_en      = 1'b1;
    bus_m.address    = 32'd1040;
    bus_m.write_data = 32'h1111_2222;
    @(negedge clk);
    bus_m.wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we_n", we_n_m, 0);
    chk("pre_rst_addr", addr_m, 18'd9);
    #3;
    rst_n = 1'b0;
    bus_m.rd_en = 1'b1;
    #1;
    chk("arst_we_n", we_n_m, 1);
    chk("arst_addr", addr_m, 0);
    chk("arst_read_data", bus_m.read_data, 0);
    chk("arst_ready_req", bus_m.ready, 0);
    chk("arst_dq_released", dq_m, mem[0]);
    bus_m.rd_en = 1'b0;
    #1;
    chk("arst_ready_idle", bus_m.ready, 1);
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;

    @(negedge clk);
    v = '{1'b1, 1'b0, 32'd1036, 32'h0000_0000, 18'd6, 32'h0BADC0DE};
    txn(v);
    @(negedge clk);
    chk("post_rst_gap_ready", bus_m.ready, 1);

    // HALF_CYCLES = 1 and 3, address wrapping below BASE_ADDR.
    @(negedge clk);
    bus_1.wr_en = 1'b1; bus_1.address = 32'd1020; bus_1.write_data = 32'h89AB_CDEF;
    bus_3.wr_en = 1'b1; bus_3.address = 32'd1020; bus_3.write_data = 32'h89AB_CDEF;
    z1 = 0;
    z3 = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      else #1;
      if (k == 1) begin
        bus_1.wr_en = 1'b0; bus_1.address = 32'd0; bus_1.write_data = 32'd0;
        bus_3.wr_en = 1'b0; bus_3.address = 32'd0; bus_3.write_data = 32'd0;
      end
      if (!bus_1.ready) z1++;
      if (!bus_3.ready) z3++;
      chk("h1_addr", addr_1, sw_addr(1, k));
      chk("h3_addr", addr_3, sw_addr(3, k));
      chk("h1_ready", bus_1.ready, sw_ready(1, k));
      chk("h3_ready", bus_3.ready, sw_ready(3, k));
      if (sw_addr(1, k) != 18'd0) chk("h1_dq", dq_1, (k > 1) ? 16'h89AB : 16'hCDEF);
      if (sw_addr(3, k) != 18'd0) chk("h3_dq", dq_3, (k > 3) ? 16'h89AB : 16'hCDEF);
    end
    chk("h1_stall", z1, 3);
    chk("h3_stall", z3, 7);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
